// File: rtl/ram_sc_be_stream.sv
// ram_sc_be_stream: single-clock block RAM with per-lane write enables, a
// valid/ready read stream, write-first forwarding on same-row collisions and
// an optional zeroing sweep after reset.
//
// Ports:
//   clk_in, reset_in          clock, synchronous active-high reset
//   busy_out                  high while the post-reset clear sweep runs
//   wrValid_in/wrReady_out    write handshake; wrMask_in selects lanes,
//   wrAddr_in, wrData_in      lane i = wrData_in[i*LANE_NBITS +: LANE_NBITS]
//   rdValid_in/rdReady_out    read request handshake, rdAddr_in selects row
//   rdValid_out/rdReady_in    read response handshake, data on rdData_out
module ram_sc_be_stream #(
  parameter int unsigned ADDR_NBITS     = 5,
  parameter int unsigned NUM_LANES      = 8,
  parameter int unsigned LANE_NBITS     = 8,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic                                 clk_in,
  input  logic                                 reset_in,
  output logic                                 busy_out,
  input  logic                                 wrValid_in,
  output logic                                 wrReady_out,
  input  logic [NUM_LANES-1:0]                 wrMask_in,
  input  logic [ADDR_NBITS-1:0]                wrAddr_in,
  input  logic [NUM_LANES*LANE_NBITS-1:0]      wrData_in,
  input  logic                                 rdValid_in,
  output logic                                 rdReady_out,
  input  logic [ADDR_NBITS-1:0]                rdAddr_in,
  output logic                                 rdValid_out,
  input  logic                                 rdReady_in,
  output logic [NUM_LANES*LANE_NBITS-1:0]      rdData_out
);

  localparam int unsigned DATA_NBITS = NUM_LANES * LANE_NBITS;
  localparam int unsigned DEPTH      = 2 ** ADDR_NBITS;
  localparam logic [ADDR_NBITS-1:0] LAST_ROW = '1;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  typedef logic [NUM_LANES-1:0][LANE_NBITS-1:0] row_t;

  state_e                state_q, state_d;
  logic [ADDR_NBITS-1:0] clr_cnt_q, clr_cnt_d;
  logic                  rd_valid_q, rd_valid_d;
  logic [NUM_LANES-1:0]  fwd_mask_q, fwd_mask_d;
  row_t                  fwd_data_q, fwd_data_d;
  row_t                  ram_rd_q;

  row_t                  mem [DEPTH];

  logic                  run;
  logic                  wr_fire;
  logic                  rd_fire;
  logic [NUM_LANES-1:0]  mem_be;
  logic [ADDR_NBITS-1:0] mem_waddr;
  row_t                  mem_wdata;
  row_t                  rd_data;

  // Handshakes; nothing is accepted during the reset cycle.
  assign run         = (state_q == ST_RUN);
  assign busy_out    = (state_q == ST_CLEAR);
  assign wrReady_out = run;
  assign rdReady_out = run & (~rd_valid_q | rdReady_in);
  assign wr_fire     = wrValid_in & run & ~reset_in;
  assign rd_fire     = rdValid_in & rdReady_out & ~reset_in;

  // Clear sweep sequencing.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    if (state_q == ST_CLEAR) begin
      clr_cnt_d = clr_cnt_q + ADDR_NBITS'(1);
      if (clr_cnt_q == LAST_ROW) begin
        state_d = ST_RUN;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q   <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // Single shared write port: the clear sweep or the user write.
  always_comb begin
    mem_be    = '0;
    mem_waddr = wrAddr_in;
    mem_wdata = row_t'(wrData_in);
    if (state_q == ST_CLEAR) begin
      mem_be    = '1;
      mem_waddr = clr_cnt_q;
      mem_wdata = '0;
    end else if (wr_fire) begin
      mem_be = wrMask_in;
    end
    if (reset_in) begin
      mem_be = '0;
    end
  end

  always_ff @(posedge clk_in) begin
    for (int i = 0; i < NUM_LANES; i++) begin
      if (mem_be[i]) begin
        mem[mem_waddr][i] <= mem_wdata[i];
      end
    end
  end

  // RAM output register; only loads on an accepted read so a stalled beat
  // keeps its snapshot even if the row is rewritten.
  always_ff @(posedge clk_in) begin
    if (rd_fire) begin
      ram_rd_q <= mem[rdAddr_in];
`ifndef SYNTHESIS
      if ($isunknown(rdAddr_in)) begin
        ram_rd_q <= 'x;
      end
`endif
    end
  end

  // Response valid plus the forwarding lanes captured alongside the read.
  always_comb begin
    rd_valid_d = rd_valid_q;
    fwd_mask_d = fwd_mask_q;
    fwd_data_d = fwd_data_q;
    if (rd_fire) begin
      rd_valid_d = 1'b1;
      fwd_data_d = row_t'(wrData_in);
      fwd_mask_d = (wr_fire && (wrAddr_in == rdAddr_in)) ? wrMask_in : '0;
`ifndef SYNTHESIS
      if ($isunknown(rdAddr_in)) begin
        fwd_mask_d = '0;
      end
`endif
    end else if (rdReady_in) begin
      rd_valid_d = 1'b0;
    end
  end

  // Reset forces every lane onto the zeroed forwarding register, so the
  // output reads zero without needing a clear on the RAM output register.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      rd_valid_q <= 1'b0;
      fwd_mask_q <= '1;
      fwd_data_q <= '0;
    end else begin
      rd_valid_q <= rd_valid_d;
      fwd_mask_q <= fwd_mask_d;
      fwd_data_q <= fwd_data_d;
    end
  end

  // Write-first merge after the RAM output register.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      rd_data[i] = fwd_mask_q[i] ? fwd_data_q[i] : ram_rd_q[i];
    end
  end

  assign rdValid_out = rd_valid_q;
  assign rdData_out  = DATA_NBITS'(rd_data);

endmodule

// File: tb/tb_ram_sc_be_stream.sv
// Self-checking bench for ram_sc_be_stream (32 rows, 8 lanes of 8 bits).
module tb_ram_sc_be_stream;

  logic        clk_in;
  logic        reset_in;
  logic        busy_out;
  logic        wrValid_in;
  logic        wrReady_out;
  logic [7:0]  wrMask_in;
  logic [4:0]  wrAddr_in;
  logic [63:0] wrData_in;
  logic        rdValid_in;
  logic        rdReady_out;
  logic [4:0]  rdAddr_in;
  logic        rdValid_out;
  logic        rdReady_in;
  logic [63:0] rdData_out;

  ram_sc_be_stream #(
    .ADDR_NBITS(5), .NUM_LANES(8), .LANE_NBITS(8), .CLEAR_ON_RESET(1'b1)
  ) dut (
    .clk_in(clk_in), .reset_in(reset_in), .busy_out(busy_out),
    .wrValid_in(wrValid_in), .wrReady_out(wrReady_out), .wrMask_in(wrMask_in),
    .wrAddr_in(wrAddr_in), .wrData_in(wrData_in),
    .rdValid_in(rdValid_in), .rdReady_out(rdReady_out), .rdAddr_in(rdAddr_in),
    .rdValid_out(rdValid_out), .rdReady_in(rdReady_in), .rdData_out(rdData_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  int errors = 0;
  int checks = 0;

  // Reference model: row contents, clear cycles still to run, response slot.
  logic [63:0] m_mem [32];
  int          m_busy = 32;
  logic        m_vld  = 1'b0;
  logic [63:0] m_data = '0;

  // Drive one cycle of inputs, advance the model across the edge, settle.
  task automatic drive_cycle(input bit rst, input bit wv, input logic [7:0] wm,
                             input logic [4:0] wa, input logic [63:0] wd,
                             input bit rv, input logic [4:0] ra, input bit rr);
    bit wacc, racc;
    logic [63:0] row;
    reset_in   = rst;
    wrValid_in = wv;
    wrMask_in  = wm;
    wrAddr_in  = wa;
    wrData_in  = wd;
    rdValid_in = rv;
    rdAddr_in  = ra;
    rdReady_in = rr;
    wacc = !rst && (m_busy == 0) && wv;
    racc = !rst && (m_busy == 0) && rv && (!m_vld || rr);
    @(posedge clk_in);
    if (rst) begin
      m_vld  = 1'b0;
      m_data = '0;
      m_busy = 32;
      for (int r = 0; r < 32; r++) m_mem[r] = '0;
    end else begin
      if (m_busy > 0) m_busy--;
      if (wacc) begin
        row = m_mem[wa];
        for (int l = 0; l < 8; l++)
          if (wm[l]) row[l*8 +: 8] = wd[l*8 +: 8];
        m_mem[wa] = row;
      end
      if (racc) begin
        m_vld  = 1'b1;
        m_data = m_mem[ra];
      end else if (rr) begin
        m_vld = 1'b0;
      end
    end
    #1;
  endtask

  task automatic idle();
    drive_cycle(0, 0, 8'h00, 5'd0, 64'd0, 0, 5'd0, 1);
  endtask

  task automatic rd(input logic [4:0] a);
    drive_cycle(0, 0, 8'h00, 5'd0, 64'd0, 1, a, 1);
  endtask

  task automatic wr(input logic [4:0] a, input logic [7:0] m, input logic [63:0] d);
    drive_cycle(0, 1, m, a, d, 0, 5'd0, 1);
  endtask

  task automatic test_reset();
    int n;
    drive_cycle(1, 0, 8'h00, 5'd0, 64'd0, 0, 5'd0, 1);
    drive_cycle(1, 0, 8'h00, 5'd0, 64'd0, 0, 5'd0, 1);
    checks++; if (rdValid_out !== 1'b0) begin errors++; $display("FAIL rst_rdvalid: got %b want 0", rdValid_out); end
    checks++; if (rdData_out !== 64'd0) begin errors++; $display("FAIL rst_rddata: got %h want 0", rdData_out); end
    checks++; if (busy_out !== 1'b1) begin errors++; $display("FAIL rst_busy: got %b want 1", busy_out); end
    checks++; if (wrReady_out !== 1'b0) begin errors++; $display("FAIL rst_wrready: got %b want 0", wrReady_out); end
    checks++; if (rdReady_out !== 1'b0) begin errors++; $display("FAIL rst_rdready: got %b want 0", rdReady_out); end
    n = 0;
    for (int k = 0; k < 40 && busy_out === 1'b1; k++) begin
      n++;
      idle();
    end
    checks++; if (n !== 32) begin errors++; $display("FAIL rst_busy_len: got %0d want 32", n); end
  endtask

  task automatic test_clear();
    int n;
    wr(5'd0, 8'hFF, {$urandom, $urandom} | 64'd1);
    wr(5'd17, 8'hFF, {$urandom, $urandom} | 64'd1);
    wr(5'd31, 8'hFF, {$urandom, $urandom} | 64'd1);
    for (int k = 0; k < 9; k++) wr(5'($urandom_range(0, 31)), 8'hFF, {$urandom, $urandom});
    drive_cycle(1, 0, 8'h00, 5'd0, 64'd0, 0, 5'd0, 1);
    n = 0;
    for (int k = 0; k < 40 && busy_out === 1'b1; k++) begin
      n++;
      checks++;
      if (wrReady_out !== 1'b0 || rdReady_out !== 1'b0) begin
        errors++; $display("FAIL clear_readies: got wr=%b rd=%b want 0 0", wrReady_out, rdReady_out);
      end
      // Requests during the sweep must be ignored.
      drive_cycle(0, 1, 8'hFF, 5'($urandom_range(0, 31)), 64'hDEAD_BEEF_0000_0001,
                  1, 5'($urandom_range(0, 31)), 1);
    end
    checks++; if (n !== 32) begin errors++; $display("FAIL clear_busy_len: got %0d want 32", n); end
    idle();
    rd(5'd0);
    checks++; if (rdValid_out !== 1'b1 || rdData_out !== 64'd0) begin errors++; $display("FAIL clear_row0: got v=%b %h want 1 0", rdValid_out, rdData_out); end
    rd(5'd17);
    checks++; if (rdData_out !== 64'd0) begin errors++; $display("FAIL clear_row17: got %h want 0", rdData_out); end
    rd(5'd31);
    checks++; if (rdData_out !== 64'd0) begin errors++; $display("FAIL clear_row31: got %h want 0", rdData_out); end
    idle();
  endtask

  task automatic test_masked_write();
    wr(5'd3, 8'hFF, 64'h1122334455667788);
    wr(5'd3, 8'h0F, 64'hAAAAAAAAAAAAAAAA);
    checks++; if (wrReady_out !== 1'b1) begin errors++; $display("FAIL mask_wrready: got %b want 1", wrReady_out); end
    rd(5'd3);
    checks++; if (rdValid_out !== 1'b1 || rdData_out !== 64'h11223344AAAAAAAA) begin
      errors++; $display("FAIL mask_read: got v=%b %h want 1 11223344aaaaaaaa", rdValid_out, rdData_out);
    end
    wr(5'd4, 8'h00, 64'hFFFFFFFFFFFFFFFF);
    rd(5'd4);
    checks++; if (rdData_out !== 64'd0) begin errors++; $display("FAIL mask_zero_noop: got %h want 0", rdData_out); end
    idle();
  endtask

  task automatic test_same_cycle();
    wr(5'd5, 8'hFF, 64'd0);
    drive_cycle(0, 1, 8'hF0, 5'd5, 64'hFFFFFFFFFFFFFFFF, 1, 5'd5, 1);
    checks++; if (rdData_out !== 64'hFFFFFFFF00000000) begin errors++; $display("FAIL rdw_fwd: got %h want ffffffff00000000", rdData_out); end
    rd(5'd5);
    checks++; if (rdData_out !== 64'hFFFFFFFF00000000) begin errors++; $display("FAIL rdw_later: got %h want ffffffff00000000", rdData_out); end
    drive_cycle(0, 1, 8'hFF, 5'd6, 64'h0123456789ABCDEF, 1, 5'd5, 1);
    checks++; if (rdData_out !== 64'hFFFFFFFF00000000) begin errors++; $display("FAIL rdw_diff_addr: got %h want ffffffff00000000", rdData_out); end
    idle();
  endtask

  task automatic test_backpressure();
    rd(5'd3);
    checks++; if (rdData_out !== 64'h11223344AAAAAAAA) begin errors++; $display("FAIL bp_first: got %h want 11223344aaaaaaaa", rdData_out); end
    for (int k = 0; k < 4; k++) begin
      drive_cycle(0, 1, 8'hFF, 5'd3, 64'd0, 1, 5'd3, 0);
      checks++;
      if (rdValid_out !== 1'b1 || rdReady_out !== 1'b0 || rdData_out !== 64'h11223344AAAAAAAA) begin
        errors++; $display("FAIL bp_stall: got v=%b rdy=%b %h want 1 0 11223344aaaaaaaa", rdValid_out, rdReady_out, rdData_out);
      end
    end
    idle();
    checks++; if (rdValid_out !== 1'b0 || rdData_out !== 64'h11223344AAAAAAAA) begin
      errors++; $display("FAIL bp_drain: got v=%b %h want 0 11223344aaaaaaaa", rdValid_out, rdData_out);
    end
    rd(5'd3);
    checks++; if (rdData_out !== 64'd0) begin errors++; $display("FAIL bp_reread: got %h want 0", rdData_out); end
    idle();
  endtask

  task automatic test_streaming();
    for (int k = 0; k < 32; k++) wr(5'(k), 8'hFF, 64'(k));
    for (int k = 0; k < 32; k++) begin
      rd(5'(k));
      checks++;
      if (rdValid_out !== 1'b1 || rdData_out !== 64'(k)) begin
        errors++; $display("FAIL stream_beat%0d: got v=%b %h want 1 %h", k, rdValid_out, rdData_out, 64'(k));
      end
    end
    idle();
    checks++; if (rdValid_out !== 1'b0) begin errors++; $display("FAIL stream_end: got %b want 0", rdValid_out); end
  endtask

  task automatic test_random();
    bit exp_rdy;
    for (int k = 0; k < 300; k++) begin
      drive_cycle(0, 1'($urandom_range(0, 1)), 8'($urandom), 5'($urandom_range(0, 3)),
                  {$urandom, $urandom}, 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 3)), $urandom_range(0, 3) != 0);
      checks++;
      if (rdValid_out !== m_vld) begin errors++; $display("FAIL rand_valid@%0d: got %b want %b", k, rdValid_out, m_vld); end
      if (m_vld) begin
        checks++;
        if (rdData_out !== m_data) begin errors++; $display("FAIL rand_data@%0d: got %h want %h", k, rdData_out, m_data); end
      end
      exp_rdy = (m_busy == 0) && (!m_vld || rdReady_in);
      checks++;
      if (rdReady_out !== exp_rdy) begin errors++; $display("FAIL rand_rdready@%0d: got %b want %b", k, rdReady_out, exp_rdy); end
    end
    idle();
  endtask

  task automatic test_reset_mid_stall();
    int n;
    wr(5'd2, 8'hFF, 64'h5555AAAA5555AAAA);
    rd(5'd2);
    drive_cycle(0, 0, 8'h00, 5'd0, 64'd0, 0, 5'd0, 0);
    checks++; if (rdValid_out !== 1'b1 || rdData_out !== 64'h5555AAAA5555AAAA) begin
      errors++; $display("FAIL mid_stalled: got v=%b %h want 1 5555aaaa5555aaaa", rdValid_out, rdData_out);
    end
    drive_cycle(1, 1, 8'hFF, 5'd7, 64'h0F0F0F0F0F0F0F0F, 1, 5'd2, 0);
    checks++; if (rdValid_out !== 1'b0 || busy_out !== 1'b1 || rdData_out !== 64'd0) begin
      errors++; $display("FAIL mid_reset: got v=%b busy=%b %h want 0 1 0", rdValid_out, busy_out, rdData_out);
    end
    n = 0;
    for (int k = 0; k < 40 && busy_out === 1'b1; k++) begin
      n++;
      idle();
    end
    checks++; if (n !== 32) begin errors++; $display("FAIL mid_busy_len: got %0d want 32", n); end
    rd(5'd2);
    checks++; if (rdData_out !== 64'd0) begin errors++; $display("FAIL mid_row2: got %h want 0", rdData_out); end
    rd(5'd7);
    checks++; if (rdData_out !== 64'd0) begin errors++; $display("FAIL mid_row7: got %h want 0", rdData_out); end
    idle();
  endtask

  initial begin
    for (int r = 0; r < 32; r++) m_mem[r] = '0;
    reset_in = 1'b1; wrValid_in = 1'b0; wrMask_in = '0; wrAddr_in = '0;
    wrData_in = '0; rdValid_in = 1'b0; rdAddr_in = '0; rdReady_in = 1'b1;
    test_reset();
    test_clear();
    test_masked_write();
    test_same_cycle();
    test_backpressure();
    test_streaming();
    test_random();
    test_reset_mid_stall();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ram_sc_be_stream.md
Name: ram_sc_be_stream

Overview:
- Parametrised single-clock block-RAM with per-lane write enables, a valid/ready read port, write-first read-during-write forwarding, and an optional self-clearing sequence after reset.
- Successor to the fixed eight-lane byte-enable RAM. Lane count and lane width are now parameters.
- Sits behind PCIe DMA/register-file logic that needs a backpressurable read stream and zeroed memory after reset.

Parameters:
- ADDR_NBITS, 5, address width; depth = 2**ADDR_NBITS rows.
- NUM_LANES, 8, independently writable lanes per row.
- LANE_NBITS, 8, bits per lane; row width W = NUM_LANES*LANE_NBITS.
- CLEAR_ON_RESET, 1, if 1 every row is zeroed after reset; if 0 contents survive reset.

Ports:
- clk_in  input  1  sole clock
- reset_in  input  1  synchronous, active-high reset
- busy_out  output  1  high while the clear sequence runs
- wrValid_in  input  1  write request
- wrReady_out  output  1  write accepted when wrValid_in & wrReady_out
- wrMask_in  input  NUM_LANES  bit i enables lane i
- wrAddr_in  input  ADDR_NBITS  write row
- wrData_in  input  W  lane i = bits [i*LANE_NBITS +: LANE_NBITS]
- rdValid_in  input  1  read request
- rdReady_out  output  1  read accepted when rdValid_in & rdReady_out
- rdAddr_in  input  ADDR_NBITS  read row
- rdValid_out  output  1  rdData_out valid
- rdReady_in  input  1  downstream accepts rdData_out
- rdData_out  output  W  read data

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: rdValid_out=0; rdData_out=0; wrReady_out=0; rdReady_out=0; busy_out=CLEAR_ON_RESET.
- FSM states: CLEAR, RUN.
  - Reset enters CLEAR if CLEAR_ON_RESET=1, else RUN.
  - CLEAR writes all-zero to row clrCnt each cycle, clrCnt = 0..2**ADDR_NBITS-1. After the last row it moves to RUN.
  - busy_out is high for exactly 2**ADDR_NBITS cycles after reset deasserts.
  - In CLEAR, wrReady_out=0 and rdReady_out=0; user ports are ignored.
- wrReady_out = (state==RUN). An accepted write updates only the lanes whose mask bit is 1; other lanes keep their old value. Mask 0 is a legal no-op.
- rdReady_out = (state==RUN) & (!rdValid_out | rdReady_in). This is combinational from rdReady_in; no path from rdValid_in to rdReady_out.
- Read latency: an accepted read at cycle N gives rdValid_out=1 with data at cycle N+1.
- Back-to-back reads sustain one beat per cycle while rdReady_in=1.
- Stall: while rdValid_out & !rdReady_in, rdData_out and rdValid_out hold stable. Writes to the held row do not alter the held data (snapshot semantics).
- Drain: when rdValid_out & rdReady_in and no new read is accepted, rdValid_out=0 next cycle; rdData_out holds its last value.
- Read-during-write, same address, same cycle: lanes with the mask bit set return the new wrData_in lane; other lanes return the old contents. Different addresses do not interact.
- Reset mid-operation:
  - Drops rdValid_out on the next edge.
  - Discards the in-flight read.
  - Restarts CLEAR from row 0.
  - A write in the reset cycle is not performed.
- Simulation only: an accepted read whose address contains X/Z drives rdData_out to all-X.
- Must infer a single altsyncram for any NUM_LANES/LANE_NBITS. Any forwarding mux sits after the RAM output register.

Test Plan (ADDR_NBITS=5, NUM_LANES=8, LANE_NBITS=8):
- Clear: pulse reset_in 1 cycle after random prior writes -> busy_out high exactly 32 cycles, readies 0 throughout; then reads of rows 0, 17, 31 -> 0x0000000000000000.
- Masked write: addr 3 ← 0x1122334455667788 mask 0xFF, then addr 3 ← 0xAAAAAAAAAAAAAAAA mask 0x0F; read 3 -> 0x11223344AAAAAAAA one cycle after accept.
- Same-cycle read/write: row 5 = 0; write 0xFFFFFFFFFFFFFFFF mask 0xF0 and read 5 in the same cycle -> 0xFFFFFFFF00000000; a later read -> the same value.
- Backpressure: read row 3 (0x11223344AAAAAAAA), rdReady_in=0 for 4 cycles while writing 0 to row 3 -> rdData_out stable, rdReady_out=0, rdValid_out=1; raise rdReady_in -> exactly one beat, then a re-read returns 0.
- Streaming: reads of rows 0..31 on consecutive cycles, rdReady_in=1, row k pre-loaded with k -> 32 consecutive beats 0..31, no bubbles.
- Reset mid-stall: rdValid_out=1 and stalled, assert reset_in -> rdValid_out=0 next cycle, busy_out=1, clear reruns for 32 cycles.
